mat_tile_sched: RTL
===================

Name: mat_tile_sched

Overview:
- Tile scheduler for the 8x8 multiply array and the output-alignment FIFO stage.
- Takes a matrix job C[M x N] = A[M x K] * B[K x N] and walks C in 8x8 output tiles, row-major.
- For each tile it drives tile edge sizes (sub_scale_M/sub_scale_P), base indices and K, then issues a start handshake to the array.
- It waits for the alignment stage to report the tile fully captured, then for that report to clear, before issuing the next tile.

Parameters:
- TILE, 8, array edge; tile step in rows and columns.
- DIM_W, 8, width of the M/N/K configuration fields.
- TO_W, 16, width of the per-tile watchdog counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  job start pulse; sampled only in IDLE
- cfg_m  in  DIM_W  rows of C
- cfg_n  in  DIM_W  columns of C
- cfg_k  in  DIM_W  inner dimension
- cfg_timeout  in  TO_W  max cycles per tile; 0 disables the watchdog
- array_ready  in  1  array accepts tile_start
- align_fifo_get_all  in  1  level from the alignment stage; high = current tile fully captured
- tile_start  out  1  tile request valid; held until array_ready
- tile_row  out  DIM_W  base row of current tile
- tile_col  out  DIM_W  base column of current tile
- tile_k  out  DIM_W  registered cfg_k
- sub_scale_M  out  8  rows in current tile = min(TILE, M - tile_row)
- sub_scale_P  out  8  columns in current tile = min(TILE, N - tile_col)
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- err_timeout  out  1  sticky; cleared by the next accepted start
- tile_cnt  out  16  tiles completed in current job

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FSM in IDLE, counters 0. Reset mid-job abandons the job with no done pulse.
- FSM states: IDLE, SETUP, ISSUE, WAIT_CAP, WAIT_CLR, DONE.
- IDLE:
  - start=1: register cfg_m/n/k/timeout, clear tile_cnt and err_timeout, set tile_row=tile_col=0, busy=1.
  - If any dimension is 0, go to DONE. Otherwise go to SETUP.
  - start outside IDLE is ignored.
- SETUP (exactly 2 cycles, counted internally):
  - sub_scale_M/P are computed and registered in the first cycle.
  - They are held stable for the whole tile, because the alignment stage registers M*P one cycle late.
  - Then go to ISSUE.
- ISSUE:
  - tile_start=1 until the cycle with array_ready=1. That cycle is the handshake; go to WAIT_CAP.
  - tile_row/col/k/sub_scale must not change while tile_start=1.
- WAIT_CAP:
  - Wait for align_fifo_get_all=1, then go to WAIT_CLR.
  - If get_all is already high on entry, the tile is treated as captured (the level is sufficient).
- WAIT_CLR:
  - Wait for align_fifo_get_all=0, then tile_cnt+1 and advance.
  - Advance rule: tile_col += TILE. If tile_col+TILE >= N, set tile_col=0 and tile_row += TILE.
  - If tile_row+TILE >= M at column wrap, go to DONE; else go to SETUP.
  - Arithmetic is done in DIM_W+1 bits so 248+8 does not wrap.
- DONE: done=1 for one cycle, busy=0, back to IDLE. Outputs other than tile_cnt and err_timeout return to 0.
- Watchdog:
  - Counter reloads to 0 on ISSUE entry and increments in ISSUE/WAIT_CAP/WAIT_CLR.
  - If cfg_timeout != 0 and the count reaches cfg_timeout: err_timeout=1 and go to DONE (done still pulses).
- Latency:
  - start to first tile_start: 3 cycles (IDLE→SETUP→SETUP→ISSUE).
  - Tile clear to next tile_start: 3 cycles.
- Simultaneous events: a timeout in the same cycle as the advance condition means the advance wins and no error is flagged.

Decomposition:
- Shared package holds:
  - the FSM state encodings (one-hot, 6 bits)
  - TILE
  - a min-size helper function (edge = remaining < TILE ? remaining : TILE)
- One natural sub-module: tile_walker (row/col counters, edge-size computation, last-tile detect). The FSM and watchdog stay in the top.

Test Plan:
- M=N=K=8, array_ready=1, get_all driven high 10 cycles after handshake then low 2 cycles later → exactly 1 tile_start with row=0, col=0, sub_scale_M=8, sub_scale_P=8; done pulses once; tile_cnt=1.
- M=20, N=12, K=5 → 6 tiles in order (0,0)(0,8)(8,0)(8,8)(16,0)(16,8). sub_scale_P alternates 8,4; sub_scale_M=8,8,8,8,4,4; tile_k=5 throughout.
- cfg_n=0 with start → done pulses 2 cycles after start; tile_start never asserts; tile_cnt=0.
- array_ready held low 7 cycles in ISSUE → tile_start and all tile fields stay constant for 7 cycles; handshake on the 8th cycle.
- cfg_timeout=50 and get_all never rises → err_timeout=1 and done pulses 50 cycles after ISSUE entry. Next start clears err_timeout.
- rst_n low during WAIT_CAP of tile 3 → all outputs 0 immediately (asynchronous), no done. A new start afterwards runs a full job correctly. start pulses during busy have no effect.

Source files
------------

// File: rtl/mat_tile_sched_pkg.sv
// Shared definitions for the matrix tile scheduler: tile edge, FSM encoding
// and the edge-size helper.
package mat_tile_sched_pkg;

  localparam int unsigned TILE = 8;

  typedef enum logic [5:0] {
    S_IDLE     = 6'b000001,
    S_SETUP    = 6'b000010,
    S_ISSUE    = 6'b000100,
    S_WAIT_CAP = 6'b001000,
    S_WAIT_CLR = 6'b010000,
    S_DONE     = 6'b100000
  } sched_state_t;

  // Edge of a tile: whatever remains of the dimension, capped at the tile size.
  function automatic logic [7:0] tile_edge(input logic [15:0] remaining,
                                           input logic [15:0] tile);
    return (remaining < tile) ? remaining[7:0] : tile[7:0];
  endfunction

endpackage

// File: rtl/mat_tile_sched_tile_walker.sv
// Row-major walk over the C matrix in TILE x TILE steps: base indices,
// registered tile edge sizes and last-tile detection.
module mat_tile_sched_tile_walker #(
  parameter int unsigned DIM_W = 8,
  parameter int unsigned TILE  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             load_edge,
  input  logic             advance,
  input  logic             clear,
  input  logic [DIM_W-1:0] dim_m,
  input  logic [DIM_W-1:0] dim_n,
  output logic [DIM_W-1:0] tile_row,
  output logic [DIM_W-1:0] tile_col,
  output logic [7:0]       sub_scale_M,
  output logic [7:0]       sub_scale_P,
  output logic             last_tile
);
  import mat_tile_sched_pkg::*;

  localparam logic [DIM_W:0] STEP = (DIM_W+1)'(TILE);

  // One extra bit so a base near the top of the range does not wrap.
  logic [DIM_W:0] col_next;
  logic [DIM_W:0] row_next;
  logic [DIM_W:0] rem_m;
  logic [DIM_W:0] rem_n;
  logic           col_wrap;

  always_comb begin
    col_next  = {1'b0, tile_col} + STEP;
    row_next  = {1'b0, tile_row} + STEP;
    rem_m     = {1'b0, dim_m} - {1'b0, tile_row};
    rem_n     = {1'b0, dim_n} - {1'b0, tile_col};
    col_wrap  = (col_next >= {1'b0, dim_n});
    last_tile = col_wrap && (row_next >= {1'b0, dim_m});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_row    <= '0;
      tile_col    <= '0;
      sub_scale_M <= '0;
      sub_scale_P <= '0;
    end else if (clear || init) begin
      tile_row    <= '0;
      tile_col    <= '0;
      sub_scale_M <= '0;
      sub_scale_P <= '0;
    end else begin
      if (load_edge) begin
        sub_scale_M <= tile_edge(16'(rem_m), 16'(TILE));
        sub_scale_P <= tile_edge(16'(rem_n), 16'(TILE));
      end
      if (advance) begin
        if (col_wrap) begin
          tile_col <= '0;
          tile_row <= row_next[DIM_W-1:0];
        end else begin
          tile_col <= col_next[DIM_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/mat_tile_sched.sv
// Tile scheduler: walks C in tiles, handshakes each tile into the multiply
// array and waits for the alignment stage capture report, with a watchdog.
module mat_tile_sched #(
  parameter int unsigned TILE  = mat_tile_sched_pkg::TILE,
  parameter int unsigned DIM_W = 8,
  parameter int unsigned TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_m,
  input  logic [DIM_W-1:0] cfg_n,
  input  logic [DIM_W-1:0] cfg_k,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             array_ready,
  input  logic             align_fifo_get_all,
  output logic             tile_start,
  output logic [DIM_W-1:0] tile_row,
  output logic [DIM_W-1:0] tile_col,
  output logic [DIM_W-1:0] tile_k,
  output logic [7:0]       sub_scale_M,
  output logic [7:0]       sub_scale_P,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [15:0]      tile_cnt
);
  import mat_tile_sched_pkg::*;

  sched_state_t     state;
  logic             setup_cnt;
  logic [DIM_W-1:0] m_r;
  logic [DIM_W-1:0] n_r;
  logic [TO_W-1:0]  to_r;
  logic [TO_W-1:0]  wd_cnt;
  logic [TO_W:0]    wd_next;
  logic             wd_active;
  logic             wd_hit;
  logic             last_tile;
  logic             walk_init;
  logic             walk_load;
  logic             walk_adv;
  logic             walk_clear;

  always_comb begin
    wd_next    = {1'b0, wd_cnt} + {{TO_W{1'b0}}, 1'b1};
    wd_active  = (state == S_ISSUE) || (state == S_WAIT_CAP) || (state == S_WAIT_CLR);
    wd_hit     = wd_active && (to_r != '0) && (wd_next == {1'b0, to_r});
    walk_init  = (state == S_IDLE) && start;
    walk_load  = (state == S_SETUP) && !setup_cnt;
    walk_adv   = (state == S_WAIT_CLR) && !align_fifo_get_all;
    walk_clear = (state == S_DONE);
  end

  mat_tile_sched_tile_walker #(
    .DIM_W (DIM_W),
    .TILE  (TILE)
  ) u_walker (
    .clk         (clk),
    .rst_n       (rst_n),
    .init        (walk_init),
    .load_edge   (walk_load),
    .advance     (walk_adv),
    .clear       (walk_clear),
    .dim_m       (m_r),
    .dim_n       (n_r),
    .tile_row    (tile_row),
    .tile_col    (tile_col),
    .sub_scale_M (sub_scale_M),
    .sub_scale_P (sub_scale_P),
    .last_tile   (last_tile)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      setup_cnt   <= 1'b0;
      m_r         <= '0;
      n_r         <= '0;
      to_r        <= '0;
      wd_cnt      <= '0;
      tile_start  <= 1'b0;
      tile_k      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      tile_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (wd_active) wd_cnt <= wd_next[TO_W-1:0];
      unique case (state)
        S_IDLE: begin
          if (start) begin
            m_r         <= cfg_m;
            n_r         <= cfg_n;
            tile_k      <= cfg_k;
            to_r        <= cfg_timeout;
            tile_cnt    <= '0;
            err_timeout <= 1'b0;
            busy        <= 1'b1;
            setup_cnt   <= 1'b0;
            if ((cfg_m == '0) || (cfg_n == '0) || (cfg_k == '0)) state <= S_DONE;
            else                                                 state <= S_SETUP;
          end
        end
        S_SETUP: begin
          setup_cnt <= ~setup_cnt;
          if (setup_cnt) begin
            state      <= S_ISSUE;
            tile_start <= 1'b1;
            wd_cnt     <= '0;
          end
        end
        S_ISSUE: begin
          if (wd_hit) begin
            err_timeout <= 1'b1;
            tile_start  <= 1'b0;
            state       <= S_DONE;
          end else if (array_ready) begin
            tile_start <= 1'b0;
            state      <= S_WAIT_CAP;
          end
        end
        S_WAIT_CAP: begin
          if (wd_hit) begin
            err_timeout <= 1'b1;
            state       <= S_DONE;
          end else if (align_fifo_get_all) begin
            state <= S_WAIT_CLR;
          end
        end
        S_WAIT_CLR: begin
          // Clearing the capture report takes priority over a coincident watchdog expiry.
          if (!align_fifo_get_all) begin
            tile_cnt  <= tile_cnt + 16'd1;
            setup_cnt <= 1'b0;
            state     <= last_tile ? S_DONE : S_SETUP;
          end else if (wd_hit) begin
            err_timeout <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          tile_start <= 1'b0;
          tile_k     <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
